// File: rtl/counter_pkg.sv
// Shared constants and helpers for the up/down modulo counter family.
// Pure declarations, no timing or flow control.
package counter_pkg;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  // Limits a load value to the legal count range 0..mod-1.
  function automatic logic [31:0] clamp_mod(input logic [31:0] val, input logic [31:0] mod);
    return (val >= mod) ? (mod - 32'd1) : val;
  endfunction

endpackage

// File: rtl/counter_tc_detect.sv
// Combinational Out==0 / Out==MOD-1 detect, shared by terminal count and next-state logic.
// Zero latency; no flow control.
module counter_tc_detect #(
  parameter int WIDTH = 5,
  parameter int MOD   = 32
) (
  input  logic [WIDTH-1:0] i_cnt,
  output logic             o_is_zero,
  output logic             o_is_max
);

  localparam logic [WIDTH:0] MAX_EXT = {1'b0, WIDTH'(MOD - 1)};

  assign o_is_zero = (i_cnt == '0);
  assign o_is_max  = ({1'b0, i_cnt} == MAX_EXT);

endmodule

// File: rtl/counter_updown_mod.sv
// Parametrised up/down modulo counter with load, registered carry/borrow pulses and comb terminal count.
// One-cycle update per enabled edge, never stalls; COUNTER_SAT_EN selects saturating instead of wrapping ends.
module counter_updown_mod
  import counter_pkg::*;
#(
  parameter int WIDTH     = 5,
  parameter int MOD       = 32,
  parameter int RESET_VAL = 0
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             E,
  input  logic             D,
  input  logic             Load,
  input  logic [WIDTH-1:0] Load_Val,
  output logic [WIDTH-1:0] Out,
  output logic             O_Carry,
  output logic             O_Borrow,
  output logic             O_Tc
);

  localparam logic [WIDTH-1:0] MAX_V   = WIDTH'(MOD - 1);
  localparam logic [WIDTH-1:0] RST_V   = WIDTH'(RESET_VAL);
  localparam logic [WIDTH:0]   ONE_EXT = 1;

  logic [WIDTH-1:0] r_out;
  logic             r_carry;
  logic             r_borrow;

  logic             w_is_zero;
  logic             w_is_max;
  logic [WIDTH:0]   w_cnt_ext;
  logic [WIDTH:0]   w_inc;
  logic [WIDTH:0]   w_dec;
  logic             w_up_wrap;
  logic             w_dn_wrap;
  logic [WIDTH-1:0] w_up_val;
  logic [WIDTH-1:0] w_dn_val;
  logic [WIDTH-1:0] w_load_val;

  counter_tc_detect #(
    .WIDTH (WIDTH),
    .MOD   (MOD)
  ) u_tc_detect (
    .i_cnt     (r_out),
    .o_is_zero (w_is_zero),
    .o_is_max  (w_is_max)
  );

  assign w_cnt_ext  = {1'b0, r_out};
  assign w_inc      = w_cnt_ext + ONE_EXT;
  assign w_dec      = w_cnt_ext - ONE_EXT;
  // The extra bit covers MOD == 2**WIDTH, where the end of range is plain overflow.
  assign w_up_wrap  = w_is_max | w_inc[WIDTH];
  assign w_dn_wrap  = w_is_zero | w_dec[WIDTH];
  assign w_load_val = WIDTH'(clamp_mod(32'(Load_Val), 32'(MOD)));

`ifdef COUNTER_SAT_EN
  assign w_up_val = w_up_wrap ? MAX_V : w_inc[WIDTH-1:0];
  assign w_dn_val = w_dn_wrap ? '0    : w_dec[WIDTH-1:0];
`else
  assign w_up_val = w_up_wrap ? '0    : w_inc[WIDTH-1:0];
  assign w_dn_val = w_dn_wrap ? MAX_V : w_dec[WIDTH-1:0];
`endif

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_out    <= RST_V;
      r_carry  <= 1'b0;
      r_borrow <= 1'b0;
    end else begin
      r_carry  <= 1'b0;
      r_borrow <= 1'b0;
      if (Load) begin
        r_out <= w_load_val;
      end else if (E) begin
        if (D == DIR_UP) begin
          r_out   <= w_up_val;
          r_carry <= w_up_wrap;
        end else begin
          r_out    <= w_dn_val;
          r_borrow <= w_dn_wrap;
        end
      end
    end
  end

  assign Out      = r_out;
  assign O_Carry  = r_carry;
  assign O_Borrow = r_borrow;
  assign O_Tc     = E & ((D == DIR_UP) ? w_is_max : w_is_zero);

endmodule

// File: tb/tb_counter_updown_mod.sv
// Directed bench for counter_updown_mod (WIDTH=5, MOD=24): literal expectations plus a per-cycle reference model.
module tb_counter_updown_mod;

  localparam int WIDTH = 5;
  localparam int MOD   = 24;

  logic             Clk;
  logic             Rst_n;
  logic             E;
  logic             D;
  logic             Load;
  logic [WIDTH-1:0] Load_Val;
  logic [WIDTH-1:0] Out;
  logic             O_Carry;
  logic             O_Borrow;
  logic             O_Tc;

  int n_chk  = 0;
  int n_pass = 0;

  counter_updown_mod #(
    .WIDTH     (WIDTH),
    .MOD       (MOD),
    .RESET_VAL (0)
  ) dut (
    .Clk      (Clk),
    .Rst_n    (Rst_n),
    .E        (E),
    .D        (D),
    .Load     (Load),
    .Load_Val (Load_Val),
    .Out      (Out),
    .O_Carry  (O_Carry),
    .O_Borrow (O_Borrow),
    .O_Tc     (O_Tc)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Reference model: modular arithmetic straight from the counting rules.
  int m_out   = 0;
  bit m_carry = 1'b0;
  bit m_borr  = 1'b0;
  bit m_valid = 1'b0;
`ifdef COUNTER_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  always @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      m_out   = 0;
      m_carry = 1'b0;
      m_borr  = 1'b0;
      m_valid = 1'b1;
    end else begin
      m_carry = 1'b0;
      m_borr  = 1'b0;
      if (Load) begin
        m_out = (int'(Load_Val) > MOD - 1) ? MOD - 1 : int'(Load_Val);
      end else if (E && D) begin
        m_carry = (m_out == MOD - 1);
        m_out   = SAT ? ((m_out + 1 > MOD - 1) ? MOD - 1 : m_out + 1) : (m_out + 1) % MOD;
      end else if (E) begin
        m_borr = (m_out == 0);
        m_out  = SAT ? ((m_out - 1 < 0) ? 0 : m_out - 1) : (m_out - 1 + MOD) % MOD;
      end
    end
  end

  always @(negedge Clk) begin
    if (m_valid) begin
      bit exp_tc;
      exp_tc = E && (D ? (m_out == MOD - 1) : (m_out == 0));
      n_chk++;
      if (int'(Out) === m_out && O_Carry === m_carry && O_Borrow === m_borr &&
          O_Tc === exp_tc && !(O_Carry && O_Borrow)) begin
        n_pass++;
      end else begin
        $display("FAIL model t=%0t got out=%0d c=%b b=%b tc=%b required out=%0d c=%b b=%b tc=%b",
                 $time, Out, O_Carry, O_Borrow, O_Tc, m_out, m_carry, m_borr, exp_tc);
      end
    end
  end

  task automatic chk(input string nm, input int eo, input bit ec, input bit eb, input bit etc);
    n_chk++;
    if (int'(Out) === eo && O_Carry === ec && O_Borrow === eb && O_Tc === etc) begin
      n_pass++;
    end else begin
      $display("FAIL %s got out=%0d c=%b b=%b tc=%b required out=%0d c=%b b=%b tc=%b",
               nm, Out, O_Carry, O_Borrow, O_Tc, eo, ec, eb, etc);
    end
  endtask

  // Drive inputs, let one rising edge pass, then settle 2 ns after it.
  task automatic cyc(input bit l, input int v, input bit e, input bit d);
    Load     = l;
    Load_Val = WIDTH'(v);
    E        = e;
    D        = d;
    @(posedge Clk);
    #2;
  endtask

  task automatic rst_pulse(input string nm, input bit etc);
    Rst_n = 1'b0;
    #1;
    chk(nm, 0, 1'b0, 1'b0, etc);
    #1;
    Rst_n = 1'b1;
  endtask

  initial begin
    Rst_n    = 1'b1;
    Load     = 1'b0;
    E        = 1'b0;
    D        = 1'b1;
    Load_Val = '0;

    // 1. asynchronous reset with no clock edge
    #3;
    Rst_n = 1'b0;
    #1;
    chk("async_reset", 0, 1'b0, 1'b0, 1'b0);
    @(posedge Clk);
    #2;
    Rst_n = 1'b1;

`ifndef COUNTER_SAT_EN
    // 2. load 20, count up across the wrap
    cyc(1, 20, 0, 1); chk("load20", 20, 0, 0, 0);
    cyc(0, 0, 1, 1);  chk("up21", 21, 0, 0, 0);
    cyc(0, 0, 1, 1);  chk("up22", 22, 0, 0, 0);
    cyc(0, 0, 1, 1);  chk("up23_tc", 23, 0, 0, 1);
    cyc(0, 0, 1, 1);  chk("wrap0_carry", 0, 1, 0, 0);
    cyc(0, 0, 1, 1);  chk("up1_nocarry", 1, 0, 0, 0);

    // 3. load 2, count down across the wrap
    cyc(1, 2, 0, 0);  chk("load2", 2, 0, 0, 0);
    cyc(0, 0, 1, 0);  chk("dn1", 1, 0, 0, 0);
    cyc(0, 0, 1, 0);  chk("dn0_tc", 0, 0, 0, 1);
    cyc(0, 0, 1, 0);  chk("wrap23_borrow", 23, 0, 1, 0);
    cyc(0, 0, 1, 0);  chk("dn22", 22, 0, 0, 0);

    // pending carry cleared by reset
    cyc(1, 23, 0, 1); chk("load23", 23, 0, 0, 0);
    cyc(0, 0, 1, 1);  chk("carry_before_rst", 0, 1, 0, 0);
    rst_pulse("rst_clears_carry", 1'b0);
`else
    // saturating ends
    cyc(1, 22, 0, 1); chk("sat_load22", 22, 0, 0, 0);
    cyc(0, 0, 1, 1);  chk("sat_up23", 23, 0, 0, 1);
    cyc(0, 0, 1, 1);  chk("sat_hold1", 23, 1, 0, 1);
    cyc(0, 0, 1, 1);  chk("sat_hold2", 23, 1, 0, 1);
    cyc(1, 1, 0, 0);  chk("sat_load1", 1, 0, 0, 0);
    cyc(0, 0, 1, 0);  chk("sat_dn0", 0, 0, 0, 1);
    cyc(0, 0, 1, 0);  chk("sat_hold0", 0, 0, 1, 1);
`endif

    // 4. load clamp, load priority over enable
    cyc(1, 30, 1, 1); chk("clamp30", 23, 0, 0, 1);
    cyc(1, 7, 0, 1);  chk("load7", 7, 0, 0, 0);

    // 5. hold, then direction change
    cyc(1, 9, 0, 0);  chk("load9", 9, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      cyc(0, 0, 0, 1); chk("hold9", 9, 0, 0, 0);
    end
    cyc(1, 12, 0, 1); chk("load12", 12, 0, 0, 0);
    cyc(0, 0, 1, 1);  chk("up13", 13, 0, 0, 0);
    cyc(0, 0, 1, 0);  chk("dir_dn12", 12, 0, 0, 0);
    cyc(0, 0, 1, 0);  chk("dn11", 11, 0, 0, 0);

    // 6. reset mid-count, then resume normally
    cyc(1, 9, 0, 1);  chk("load9b", 9, 0, 0, 0);
    cyc(0, 0, 1, 1);  chk("up10", 10, 0, 0, 0);
    rst_pulse("rst_mid_count", 1'b0);
    cyc(0, 0, 1, 1);  chk("after_rst_up1", 1, 0, 0, 0);

    cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 1);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
